// File: rtl/pea_firing_scheduler.sv
// Firing scheduler for the PEA actor: gates invoke on FIFO tokens/space for the current mode.
// Latency: enable seen in CHECK -> invoke next cycle; FC -> new mode next cycle, next invoke 2 cycles later.
// Backpressure: stalls in CHECK until pops/free space satisfy the mode; a watchdog halts on missing FC.
module pea_firing_scheduler #(
    parameter int WORD_SIZE      = 16,
    parameter int BUFFER_SIZE    = 1024,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           run,
    input  logic [$clog2(BUFFER_SIZE)-1:0] command_pop,
    input  logic [$clog2(BUFFER_SIZE)-1:0] data_pop,
    input  logic [$clog2(BUFFER_SIZE)-1:0] result_free_space,
    input  logic [$clog2(BUFFER_SIZE)-1:0] status_free_space,
    input  logic [4:0]                     tokens_needed,
    input  logic                           FC,
    input  logic [1:0]                     next_mode_in,
    output logic                           invoke,
    output logic [1:0]                     mode,
    output logic                           busy,
    output logic                           timeout_err,
    output logic [WORD_SIZE-1:0]           firing_count
);

    localparam int PW  = $clog2(BUFFER_SIZE);
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_INVOKE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [1:0] M_COMMAND = 2'b00;
    localparam logic [1:0] M_LOAD    = 2'b01;
    localparam logic [1:0] M_EVAL    = 2'b10;
    localparam logic [1:0] M_OUTPUT  = 2'b11;

    logic [2:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [WORD_SIZE-1:0] firing_count_q, firing_count_d;
    logic [WDW-1:0]       wd_q, wd_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [PW-1:0]        n_tok;
    logic                 fire_ok;

    // A firing always consumes or produces at least one token, so 0 is treated as 1.
    always_comb begin
        n_tok = PW'(1);
        if (tokens_needed != 5'd0) begin
            n_tok = PW'(tokens_needed);
        end
    end

    always_comb begin
        fire_ok = 1'b0;
        case (mode_q)
            M_COMMAND: fire_ok = (command_pop >= PW'(1));
            M_LOAD:    fire_ok = (data_pop >= n_tok);
            M_EVAL:    fire_ok = (data_pop >= n_tok) && (result_free_space >= n_tok);
            M_OUTPUT:  fire_ok = (result_free_space >= PW'(1)) && (status_free_space >= PW'(1));
            default:   fire_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        firing_count_d = firing_count_q;
        wd_d           = wd_q;
        timeout_err_d  = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (fire_ok) begin
                    state_d = S_INVOKE;
                end
            end
            S_INVOKE: begin
                wd_d    = WD_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // FC takes priority over an expiring watchdog in the same cycle.
                if (FC) begin
                    mode_d         = next_mode_in;
                    firing_count_d = firing_count_q + WORD_SIZE'(1);
                    state_d        = run ? S_CHECK : S_IDLE;
                end else if (wd_q == '0) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_HALT;
                end else begin
                    wd_d = wd_q - WDW'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            mode_q         <= M_COMMAND;
            firing_count_q <= '0;
            wd_q           <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            firing_count_q <= firing_count_d;
            wd_q           <= wd_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign invoke       = (state_q == S_INVOKE);
    assign busy         = (state_q == S_INVOKE) || (state_q == S_WAIT);
    assign mode         = mode_q;
    assign timeout_err  = timeout_err_q;
    assign firing_count = firing_count_q;

endmodule

// File: tb/tb_pea_firing_scheduler.sv
// Bench for pea_firing_scheduler: enable-condition vector table, scoreboarded firings, corner sequences.
// Counter width is narrowed to 8 bits so the wrap case stays short.
module tb_pea_firing_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [9:0] command_pop, data_pop, result_free_space, status_free_space;
    logic [4:0] tokens_needed;
    logic       fc;
    logic [1:0] next_mode_in;
    logic       invoke;
    logic [1:0] mode;
    logic       busy;
    logic       timeout_err;
    logic [7:0] firing_count;

    pea_firing_scheduler #(
        .WORD_SIZE(8),
        .BUFFER_SIZE(1024),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .command_pop(command_pop),
        .data_pop(data_pop),
        .result_free_space(result_free_space),
        .status_free_space(status_free_space),
        .tokens_needed(tokens_needed),
        .FC(fc),
        .next_mode_in(next_mode_in),
        .invoke(invoke),
        .mode(mode),
        .busy(busy),
        .timeout_err(timeout_err),
        .firing_count(firing_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0] m;
        logic [7:0] c;
    } sb_t;

    sb_t        sbq[$];
    bit         pend = 1'b0;
    logic [1:0] exp_mode;
    logic [7:0] exp_count;

    // Compare mode/count one edge after the DUT accepts an FC in WAIT.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (sbq.size() == 0) begin
                chk("sb_unexpected_fc", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_mode", 32'(mode), 32'(e.m));
                chk("sb_count", 32'(firing_count), 32'(e.c));
            end
        end
        if (rst && busy && !invoke && fc) begin
            pend = 1'b1;
        end
    end

    task automatic do_fc(input logic [1:0] nm);
        exp_count = exp_count + 8'd1;
        exp_mode  = nm;
        sbq.push_back('{m: nm, c: exp_count});
        fc           = 1'b1;
        next_mode_in = nm;
        tick();
        fc = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_invoke"}, 32'(invoke), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_count"}, 32'(firing_count), 32'd0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [4:0] tok;
        logic [9:0] cp;
        logic [9:0] dp;
        logic [9:0] rf;
        logic [9:0] sf;
        bit         inv;
        logic [1:0] nm;
    } vec_t;

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        int n_inv;
        // mode, tokens, cmd_pop, data_pop, result_free, status_free, expect invoke, next mode
        vt[0]  = '{2'd1, 5'd9,  10'd0, 10'd8,    10'd0,  10'd0, 1'b0, 2'd1};
        vt[1]  = '{2'd1, 5'd9,  10'd0, 10'd9,    10'd0,  10'd0, 1'b1, 2'd1};
        vt[2]  = '{2'd1, 5'd0,  10'd5, 10'd0,    10'd5,  10'd5, 1'b0, 2'd1};
        vt[3]  = '{2'd1, 5'd0,  10'd0, 10'd1,    10'd0,  10'd0, 1'b1, 2'd2};
        vt[4]  = '{2'd2, 5'd4,  10'd0, 10'd10,   10'd3,  10'd9, 1'b0, 2'd2};
        vt[5]  = '{2'd2, 5'd4,  10'd0, 10'd10,   10'd4,  10'd0, 1'b1, 2'd3};
        vt[6]  = '{2'd3, 5'd0,  10'd9, 10'd9,    10'd5,  10'd0, 1'b0, 2'd3};
        vt[7]  = '{2'd3, 5'd0,  10'd9, 10'd9,    10'd0,  10'd5, 1'b0, 2'd3};
        vt[8]  = '{2'd3, 5'd0,  10'd0, 10'd0,    10'd1,  10'd1, 1'b1, 2'd0};
        vt[9]  = '{2'd0, 5'd0,  10'd0, 10'd9,    10'd9,  10'd9, 1'b0, 2'd0};
        vt[10] = '{2'd0, 5'd0,  10'd1, 10'd0,    10'd0,  10'd0, 1'b1, 2'd2};
        vt[11] = '{2'd2, 5'd31, 10'd0, 10'd31,   10'd30, 10'd0, 1'b0, 2'd2};
        vt[12] = '{2'd2, 5'd31, 10'd0, 10'd31,   10'd31, 10'd0, 1'b1, 2'd1};
        vt[13] = '{2'd1, 5'd3,  10'd0, 10'd1023, 10'd0,  10'd0, 1'b1, 2'd0};

        rst = 1'b1; run = 1'b0; fc = 1'b0; next_mode_in = 2'd0;
        command_pop = '0; data_pop = '0; result_free_space = '0; status_free_space = '0;
        tokens_needed = '0;
        exp_mode = 2'd0; exp_count = 8'd0;
        #2 rst = 1'b0;
        #2 chk_reset_vals("reset");
        tick();
        rst = 1'b1;

        // Command firing: no tokens means no invoke.
        run = 1'b1;
        tick();
        n_inv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (invoke) n_inv++;
        end
        chk("cmd_empty_no_invoke", 32'(n_inv), 32'd0);
        command_pop = 10'd3;
        tick();
        chk("cmd_invoke", 32'(invoke), 32'd1);
        chk("cmd_busy", 32'(busy), 32'd1);
        tick();
        chk("cmd_invoke_one_cycle", 32'(invoke), 32'd0);
        chk("cmd_wait_busy", 32'(busy), 32'd1);
        do_fc(2'd1);
        chk("cmd_mode_load", 32'(mode), 32'd1);
        chk("cmd_count_1", 32'(firing_count), 32'd1);

        // Enable-condition table.
        for (int i = 0; i < 14; i++) begin
            chk("vec_mode", 32'(mode), 32'(vt[i].mode));
            tokens_needed     = vt[i].tok;
            command_pop       = vt[i].cp;
            data_pop          = vt[i].dp;
            result_free_space = vt[i].rf;
            status_free_space = vt[i].sf;
            tick();
            chk("vec_invoke", 32'(invoke), 32'(vt[i].inv));
            tick();
            if (vt[i].inv) begin
                do_fc(vt[i].nm);
            end else begin
                chk("vec_stall_hold", 32'(invoke), 32'd0);
            end
        end

        // Watchdog expiry in COMMAND mode.
        command_pop = 10'd1;
        tick();
        chk("wd_invoke", 32'(invoke), 32'd1);
        tick();
        repeat (7) tick();
        chk("wd_err_early", 32'(timeout_err), 32'd0);
        chk("wd_busy_early", 32'(busy), 32'd1);
        tick();
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        chk("wd_halt_not_busy", 32'(busy), 32'd0);
        fc = 1'b1; next_mode_in = 2'd3; run = 1'b0;
        tick();
        fc = 1'b0; run = 1'b1;
        n_inv = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (invoke) n_inv++;
        end
        chk("halt_no_invoke", 32'(n_inv), 32'd0);
        chk("halt_err_sticky", 32'(timeout_err), 32'd1);
        chk("halt_mode", 32'(mode), 32'(exp_mode));
        chk("halt_count", 32'(firing_count), 32'(exp_count));
        rst = 1'b0;
        #1 chk_reset_vals("halt_rst");
        exp_mode = 2'd0; exp_count = 8'd0;
        tick();
        rst = 1'b1;

        // FC on the final watchdog cycle wins.
        data_pop = '0; result_free_space = '0;
        tick();
        tick();
        chk("tie_invoke", 32'(invoke), 32'd1);
        tick();
        repeat (7) tick();
        chk("tie_still_busy", 32'(busy), 32'd1);
        do_fc(2'd2);
        chk("tie_no_err", 32'(timeout_err), 32'd0);
        chk("tie_mode", 32'(mode), 32'd2);

        // Stray FC while idle.
        run = 1'b0;
        tick();
        fc = 1'b1; next_mode_in = 2'd3;
        tick();
        fc = 1'b0;
        tick();
        chk("stray_mode", 32'(mode), 32'd2);
        chk("stray_count", 32'(firing_count), 32'd1);

        // run dropped during WAIT: firing completes, then IDLE.
        run = 1'b1;
        tick();
        tokens_needed = 5'd1; data_pop = 10'd1; result_free_space = 10'd1;
        tick();
        chk("drop_invoke", 32'(invoke), 32'd1);
        tick();
        run = 1'b0; data_pop = 10'd0;
        tick();
        tick();
        chk("drop_wait_busy", 32'(busy), 32'd1);
        do_fc(2'd0);
        chk("drop_idle_busy", 32'(busy), 32'd0);
        command_pop = 10'd1;
        n_inv = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (invoke) n_inv++;
        end
        chk("drop_stays_idle", 32'(n_inv), 32'd0);

        // Reset asserted mid-WAIT.
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1 chk_reset_vals("midrst");
        exp_mode = 2'd0; exp_count = 8'd0;
        tick();
        rst = 1'b1;

        // Counter wrap at the narrowed width.
        tick();
        for (int i = 0; i < 256; i++) begin
            tick();
            tick();
            do_fc(2'd0);
        end
        chk("wrap_count", 32'(firing_count), 32'd0);
        run = 1'b0;
        tick();
        tick();
        chk("sb_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pea_firing_scheduler.md
# pea_firing_scheduler

Firing scheduler for the Polynomial Evaluation Accelerator actor. It watches the populations of the command and data input FIFOs and the free space of the result and status output FIFOs. It decides when the PEA actor has enough tokens and space for its current mode, then issues a one-cycle invoke and waits for firing-complete (FC). It also tracks the actor's mode across firings and guards each firing with a watchdog timeout.

## Interface
- word_size, 16, token width (used only for the firing-counter width)
- buffer_size, 1024, words per FIFO; population and free-space ports are log2(buffer_size) bits wide
- timeout_cycles, 256, maximum number of WAIT cycles allowed before FC must arrive

- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  scheduler enable; level-sensitive
- command_pop  in  log2(buffer_size)  command input FIFO population
- data_pop  in  log2(buffer_size)  data input FIFO population
- result_free_space  in  log2(buffer_size)  free words in the result output FIFO
- status_free_space  in  log2(buffer_size)  free words in the status output FIFO
- tokens_needed  in  5  data tokens (LOAD) or results (EVAL) required by the next firing, supplied by the actor (its b/Ni)
- FC  in  1  firing complete from the PEA actor; single-cycle pulse
- next_mode_in  in  2  actor's mode for its next firing; valid in the cycle FC is high
- invoke  out  1  one-cycle firing request to the PEA actor
- mode  out  2  current mode: 00 COMMAND, 01 LOAD, 10 EVAL, 11 OUTPUT
- busy  out  1  high in INVOKE and WAIT
- timeout_err  out  1  sticky watchdog error
- firing_count  out  word_size  number of completed firings

## Operation
- States are IDLE, CHECK, INVOKE, WAIT and HALT.
- **IDLE**
  - run=1 → CHECK; otherwise stay.
- **CHECK**
  - run=0 → IDLE.
  - Otherwise, if the enable condition for `mode` holds → INVOKE; else stay in CHECK.
- **INVOKE**
  - invoke=1 for exactly this cycle.
  - Watchdog is loaded with timeout_cycles−1.
  - Next state is WAIT unconditionally, even if run has dropped.
- **WAIT**
  - FC=1: latch mode ← next_mode_in, increment firing_count, go to CHECK. If run=0 in the same cycle, go to IDLE instead, still latching mode and incrementing the count.
  - FC=0 and watchdog=0: timeout_err ← 1, go to HALT.
  - Otherwise decrement the watchdog.
- **HALT**
  - Terminal state; only rst exits it.
  - invoke stays 0; FC and run are ignored.
- Enable conditions are combinational on registered `mode` and the current FIFO inputs. n = max(tokens_needed, 1), zero-extended to the pop width.
  - COMMAND: command_pop ≥ 1.
  - LOAD: data_pop ≥ n.
  - EVAL: data_pop ≥ n and result_free_space ≥ n.
  - OUTPUT: result_free_space ≥ 1 and status_free_space ≥ 1.
- firing_count wraps modulo 2^word_size.
- FC outside WAIT is ignored: no mode change, no count.
- FC in the same cycle the watchdog reaches 0: FC wins, no error.

## Timing
- **Reset values**: state IDLE, invoke 0, mode 00, busy 0, timeout_err 0, firing_count 0, watchdog 0.
- Asynchronous assertion; release is taken on the next clk edge.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
- **Latency**:
  - Enable condition true in CHECK at edge k → invoke high in cycle k+1.
  - FC high at edge j → new mode visible at j+1; earliest next invoke at j+2.
- **Minimum firing period**: 3 cycles (CHECK, INVOKE, WAIT with immediate FC).
- **Watchdog**: FC may arrive on any of WAIT cycles 1..timeout_cycles. With no FC, timeout_err rises after timeout_cycles WAIT cycles.
- Pops and free space are sampled only in CHECK; changes during WAIT have no effect.
- rst mid-firing aborts immediately: invoke and busy drop asynchronously; mode returns to COMMAND.

## Test plan
- **Reset and command firing**: reset, run=1, command_pop=0 for 5 cycles → invoke stays 0. Then command_pop=3 → invoke pulses one cycle later, busy=1. FC with next_mode_in=01 → mode=01, firing_count=1.
- **LOAD threshold**: mode LOAD, tokens_needed=9.
  - data_pop=8 → no invoke.
  - data_pop=9 → invoke.
  - With tokens_needed=0 and data_pop=0 → no invoke.
  - With tokens_needed=0 and data_pop=1 → invoke.
- **EVAL back-pressure**: mode EVAL, tokens_needed=4, data_pop=10.
  - result_free_space=3 → stall.
  - result_free_space=4 → invoke.
  - FC with next_mode_in=11, then status_free_space=0 → stall in OUTPUT.
- **Watchdog**: timeout_cycles=8, invoke with no FC → timeout_err=1 exactly 8 cycles after the WAIT entry edge, and it stays high. A later FC or a toggle of run is ignored; only rst clears it.
- **FC/watchdog tie, stray FC and wrap**:
  - FC on the 8th WAIT cycle → no error.
  - FC pulsed in IDLE → mode and count unchanged.
  - Drive 2^16 firings → firing_count wraps to 0.
- **Mid-firing reset and run drop**:
  - rst low during WAIT → all outputs at reset values immediately.
  - run dropped during WAIT → scheduler completes the firing on FC, then goes to IDLE.
